// File: rtl/sram_bist_ctrl_if.sv
// sram_bist_ctrl_if
//   Broadcast SRAM bus between the March-test engine and NUM_SRAMS single-port
//   macros. Control lines and write data are shared by all macros. Chip select
//   is per channel. Read data returns one word per channel.
//   sram_csb   [NUM_SRAMS]             active-low chip select per channel
//   sram_web   [1]                     active-low write enable (shared)
//   sram_addr  [ADDR_WIDTH]            shared address
//   sram_din   [DATA_WIDTH]            shared write data
//   sram_dout  [NUM_SRAMS*DATA_WIDTH]  read data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   master = BIST engine, slave = SRAM array.
interface sram_bist_ctrl_if #(
  parameter int NUM_SRAMS  = 11,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [NUM_SRAMS-1:0]            sram_csb;
  logic                            sram_web;
  logic [ADDR_WIDTH-1:0]           sram_addr;
  logic [DATA_WIDTH-1:0]           sram_din;
  logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_dout;

  modport master (output sram_csb, sram_web, sram_addr, sram_din, input  sram_dout);
  modport slave  (input  sram_csb, sram_web, sram_addr, sram_din, output sram_dout);
endinterface

// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl
//   March C- engine (4 elements) broadcast to NUM_SRAMS single-port macros in
//   lockstep. Each enabled channel's readback is compared one cycle after the
//   read is issued, and any mismatch sets a sticky per-channel fail flag.
//     E0 up  : W P
//     E1 up  : R P, W Q
//     E2 down: R Q, W P
//     E3 down: R P
//     FLUSH  : compare of the last E3 read
//   P(a) is picked by pattern_sel and Q(a) = ~P(a).
// Ports
//   wb_clk_i, wb_rst_i  clock, async active-high reset
//   start               level, only sampled in IDLE (latches chan_en / pattern_sel)
//   abort               synchronous return to IDLE; fail flags are kept
//   pattern_sel         00 zeros, 01 0x55.., 10 addr, 11 ~addr
//   chan_en             per-channel test enable
//   sram                SRAM bus (sram_bist_ctrl_if.master)
//   busy / done         running / finished (done held until the next start)
//   fail / fail_any     sticky per-channel mismatch, OR of fail
//   err_addr/chan/elem  first-failure capture
// Build option
//   SRAM_BIST_ERR_CAPTURE_EN: when defined, the read address, lowest failing
//   channel and March element of the first mismatch are captured and frozen
//   until the next start. When undefined, err_* are tied to 0.
module sram_bist_ctrl #(
  parameter  int NUM_SRAMS  = 11,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 8,
  localparam int CHAN_W     = (NUM_SRAMS > 1) ? $clog2(NUM_SRAMS) : 1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             pattern_sel,
  input  logic [NUM_SRAMS-1:0]   chan_en,
  sram_bist_ctrl_if.master       sram,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_SRAMS-1:0]   fail,
  output logic                   fail_any,
  output logic [ADDR_WIDTH-1:0]  err_addr,
  output logic [CHAN_W-1:0]      err_chan,
  output logic [1:0]             err_elem
);

  typedef enum logic [2:0] {S_IDLE, S_E0, S_E1, S_E2, S_E3, S_FLUSH} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_ph;        // E1/E2: 0 = read cycle, 1 = write cycle
  logic [NUM_SRAMS-1:0]    r_chan_en;
  logic [1:0]              r_sel;
  logic [NUM_SRAMS-1:0]    r_fail;
  logic                    r_done;
  logic                    r_cmp_vld;
  logic [DATA_WIDTH-1:0]   r_exp;

  logic                    w_start;
  logic [DATA_WIDTH-1:0]   w_p;
  logic [NUM_SRAMS-1:0]    w_csb;
  logic                    w_web;
  logic [DATA_WIDTH-1:0]   w_din;
  logic                    w_rd;
  logic [DATA_WIDTH-1:0]   w_exp;
  logic [NUM_SRAMS-1:0]    w_mis;

  function automatic logic [DATA_WIDTH-1:0] f_pat(input logic [1:0] sel,
                                                  input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] ck;
    logic [DATA_WIDTH-1:0] ax;
    for (int i = 0; i < DATA_WIDTH; i++) ck[i] = (i % 2 == 0);
    ax = DATA_WIDTH'(a);
    case (sel)
      2'b00:   f_pat = '0;
      2'b01:   f_pat = ck;
      2'b10:   f_pat = ax;
      default: f_pat = ~ax;
    endcase
  endfunction

  assign w_start = (r_state == S_IDLE) && start && !abort;
  assign w_p     = f_pat(r_sel, r_addr);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    if (abort) w_next = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (start)                     w_next = S_E0;
        S_E0:    if (r_addr == LAST)            w_next = S_E1;
        S_E1:    if (r_ph && r_addr == LAST)    w_next = S_E2;
        S_E2:    if (r_ph && r_addr == '0)      w_next = S_E3;
        S_E3:    if (r_addr == '0)              w_next = S_FLUSH;
        S_FLUSH:                                w_next = S_IDLE;
        default:                                w_next = S_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_csb = '1;
    w_web = 1'b1;
    w_din = '0;
    w_rd  = 1'b0;
    w_exp = '0;
    case (r_state)
      S_E0: begin
        w_csb = ~r_chan_en; w_web = 1'b0; w_din = w_p;
      end
      S_E1: begin
        w_csb = ~r_chan_en;
        if (r_ph) begin w_web = 1'b0; w_din = ~w_p; end
        else      begin w_rd  = 1'b1; w_exp = w_p;  end
      end
      S_E2: begin
        w_csb = ~r_chan_en;
        if (r_ph) begin w_web = 1'b0; w_din = w_p;  end
        else      begin w_rd  = 1'b1; w_exp = ~w_p; end
      end
      S_E3: begin
        w_csb = ~r_chan_en; w_rd = 1'b1; w_exp = w_p;
      end
      default: ;
    endcase
  end

  assign sram.sram_csb  = w_csb;
  assign sram.sram_web  = w_web;
  assign sram.sram_addr = r_addr;
  assign sram.sram_din  = w_din;

  // Address walker. On an element change the counter loads the first address
  // of the new element, so it never wraps. E2/E3 run downward from the top.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_addr <= '0;
      r_ph   <= 1'b0;
    end else if (w_next != r_state) begin
      r_ph   <= 1'b0;
      r_addr <= (w_next == S_E2 || w_next == S_E3) ? LAST : '0;
    end else begin
      case (r_state)
        S_E0: r_addr <= r_addr + ADDR_WIDTH'(1);
        S_E1: begin r_ph <= ~r_ph; if (r_ph) r_addr <= r_addr + ADDR_WIDTH'(1); end
        S_E2: begin r_ph <= ~r_ph; if (r_ph) r_addr <= r_addr - ADDR_WIDTH'(1); end
        S_E3: r_addr <= r_addr - ADDR_WIDTH'(1);
        default: ;
      endcase
    end

  // Test configuration is frozen at start so that mid-run input changes cannot
  // skew the comparison.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_chan_en <= '0;
      r_sel     <= '0;
    end else if (w_start) begin
      r_chan_en <= chan_en;
      r_sel     <= pattern_sel;
    end

  // The read issued this cycle is checked next cycle against r_exp. The valid
  // bit follows through element changes and into FLUSH, and abort drops it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_cmp_vld <= 1'b0;
      r_exp     <= '0;
    end else begin
      r_cmp_vld <= w_rd && !abort;
      r_exp     <= w_exp;
    end

  always_comb begin
    w_mis = '0;
    for (int i = 0; i < NUM_SRAMS; i++)
      w_mis[i] = r_cmp_vld && r_chan_en[i] &&
                 (sram.sram_dout[i*DATA_WIDTH +: DATA_WIDTH] != r_exp);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i)     r_fail <= '0;
    else if (w_start) r_fail <= '0;
    else              r_fail <= r_fail | w_mis;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i)                             r_done <= 1'b0;
    else if (w_start)                         r_done <= 1'b0;
    else if (r_state == S_FLUSH && !abort)    r_done <= 1'b1;

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign fail     = r_fail;
  assign fail_any = |r_fail;

`ifdef SRAM_BIST_ERR_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] r_cmp_addr;
  logic [1:0]            r_cmp_elem;
  logic [1:0]            w_elem;
  logic [CHAN_W-1:0]     w_low;
  logic                  r_err_seen;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [CHAN_W-1:0]     r_err_chan;
  logic [1:0]            r_err_elem;

  always_comb begin
    case (r_state)
      S_E1:    w_elem = 2'd1;
      S_E2:    w_elem = 2'd2;
      S_E3:    w_elem = 2'd3;
      default: w_elem = 2'd0;
    endcase
  end

  // The address and element tags follow the read through the compare stage.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_cmp_addr <= '0;
      r_cmp_elem <= '0;
    end else begin
      r_cmp_addr <= r_addr;
      r_cmp_elem <= w_elem;
    end

  // The loop runs downward so that the lowest failing index is the one kept.
  always_comb begin
    w_low = '0;
    for (int i = NUM_SRAMS-1; i >= 0; i--)
      if (w_mis[i]) w_low = CHAN_W'(i);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_err_seen <= 1'b0;
      r_err_addr <= '0;
      r_err_chan <= '0;
      r_err_elem <= '0;
    end else if (w_start) begin
      r_err_seen <= 1'b0;
      r_err_addr <= '0;
      r_err_chan <= '0;
      r_err_elem <= '0;
    end else if (|w_mis && !r_err_seen) begin
      r_err_seen <= 1'b1;
      r_err_addr <= r_cmp_addr;
      r_err_chan <= w_low;
      r_err_elem <= r_cmp_elem;
    end

  assign err_addr = r_err_addr;
  assign err_chan = r_err_chan;
  assign err_elem = r_err_elem;
`else
  assign err_addr = '0;
  assign err_chan = '0;
  assign err_elem = '0;
`endif

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: 3 channels x 16 words x 8 bits, with behavioural
// single-port SRAMs (read latency 1) and injectable faults:
//   stuck1 : channel 1 data bit 3 reads back as 1
//   alias2 : channel 2 address 5 decodes onto word 4
module tb_sram_bist_ctrl;
  localparam int NS = 3, DW = 8, AW = 4, DEPTH = 16;
  localparam int BUSY_CYC = 6*DEPTH + 1;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic [NS-1:0] chen = '0;
  logic          busy, done, fail_any;
  logic [NS-1:0] fail;
  logic [AW-1:0] err_addr;
  logic [1:0]    err_chan, err_elem;
  logic          stuck1 = 1'b0, alias2 = 1'b0;

  int n_cmp = 0, n_bad = 0;

  sram_bist_ctrl_if #(.NUM_SRAMS(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_bist_ctrl #(.NUM_SRAMS(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .pattern_sel(sel), .chan_en(chen), .sram(bus),
    .busy(busy), .done(done), .fail(fail), .fail_any(fail_any),
    .err_addr(err_addr), .err_chan(err_chan), .err_elem(err_elem));

  always #5 clk = ~clk;

  logic [DW-1:0] mem [NS][DEPTH];

  always @(posedge clk) begin
    for (int c = 0; c < NS; c++) begin
      if (!bus.sram_csb[c]) begin
        automatic int a = int'(bus.sram_addr);
        automatic logic [DW-1:0] d;
        if (alias2 && c == 2 && a == 5) a = 4;
        if (!bus.sram_web) mem[c][a] <= bus.sram_din;
        else begin
          d = mem[c][a];
          if (stuck1 && c == 1) d[3] = 1'b1;
          bus.sram_dout[c*DW +: DW] <= d;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Pulse start, then count busy cycles sampled on the falling edge. On return
  // the bench sits on the first falling edge with busy low.
  task automatic run_test(input logic [NS-1:0] ce, input logic [1:0] ps,
                          output int cyc, output logic csb1_low);
    @(negedge clk);
    chen = ce; sel = ps; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0; csb1_low = 1'b0;
    while (busy && cyc < 300) begin
      cyc++;
      if (!bus.sram_csb[1]) csb1_low = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic wait_busy_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  typedef struct {
    string         nm;
    logic [NS-1:0] ce;
    logic [1:0]    ps;
    logic          st;
    logic          al;
    logic [NS-1:0] efail;
    logic [AW-1:0] eaddr;
    logic [1:0]    echan;
    logic [1:0]    eelem;
  } vec_t;

  vec_t vt [10];

  initial begin
    int            cyc;
    logic          c1;
    logic [AW-1:0] xa;
    logic [1:0]    xc, xe;

    // Capture fields hold the read address, the lowest failing channel and the
    // element whose read failed (E1 = 1).
    vt[0] = '{"clean_sel00",   3'b111, 2'b00, 0, 0, 3'b000, 4'd0, 2'd0, 2'd0};
    vt[1] = '{"clean_sel01",   3'b111, 2'b01, 0, 0, 3'b000, 4'd0, 2'd0, 2'd0};
    vt[2] = '{"clean_sel10",   3'b111, 2'b10, 0, 0, 3'b000, 4'd0, 2'd0, 2'd0};
    vt[3] = '{"clean_sel11",   3'b111, 2'b11, 0, 0, 3'b000, 4'd0, 2'd0, 2'd0};
    vt[4] = '{"stuck_sel00",   3'b111, 2'b00, 1, 0, 3'b010, 4'd0, 2'd1, 2'd1};
    vt[5] = '{"stuck_sel01",   3'b111, 2'b01, 1, 0, 3'b010, 4'd0, 2'd1, 2'd1};
    vt[6] = '{"stuck_sel11",   3'b111, 2'b11, 1, 0, 3'b010, 4'd8, 2'd1, 2'd1};
    vt[7] = '{"alias_sel10",   3'b111, 2'b10, 0, 1, 3'b100, 4'd4, 2'd2, 2'd1};
    vt[8] = '{"stk_alias_10",  3'b111, 2'b10, 1, 1, 3'b110, 4'd0, 2'd1, 2'd1};
    vt[9] = '{"mask_101",      3'b101, 2'b00, 1, 0, 3'b000, 4'd0, 2'd0, 2'd0};

    // Reset values
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_csb", bus.sram_csb, 3'b111);
    chk("rst_web", bus.sram_web, 1);
    chk("rst_addr", bus.sram_addr, 0);
    chk("rst_din", bus.sram_din, 0);
    chk("rst_err", {err_addr, err_chan, err_elem}, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[v]) begin
      stuck1 = vt[v].st; alias2 = vt[v].al;
      run_test(vt[v].ce, vt[v].ps, cyc, c1);
`ifdef SRAM_BIST_ERR_CAPTURE_EN
      xa = vt[v].eaddr; xc = vt[v].echan; xe = vt[v].eelem;
`else
      xa = '0; xc = '0; xe = '0;
`endif
      chk({vt[v].nm, "_busycyc"}, cyc, BUSY_CYC);
      chk({vt[v].nm, "_done"}, done, 1);
      chk({vt[v].nm, "_fail"}, fail, vt[v].efail);
      chk({vt[v].nm, "_fail_any"}, fail_any, |vt[v].efail);
      chk({vt[v].nm, "_err_addr"}, err_addr, xa);
      chk({vt[v].nm, "_err_chan"}, err_chan, xc);
      chk({vt[v].nm, "_err_elem"}, err_elem, xe);
      chk({vt[v].nm, "_csb1_used"}, c1, vt[v].ce[1]);
    end
    stuck1 = 1'b0; alias2 = 1'b0;

    // done is held in IDLE until the next start
    wait_busy_cycles(3);
    chk("done_held", done, 1);
    chk("idle_csb", bus.sram_csb, 3'b111);

    // start held high through the end restarts on the next IDLE cycle
    @(negedge clk);
    chen = 3'b111; sel = 2'b01; start = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 300) begin cyc++; @(negedge clk); end
    chk("hold_busycyc", cyc, BUSY_CYC);
    chk("hold_done", done, 1);
    @(negedge clk);
    chk("hold_restart_busy", busy, 1);
    chk("hold_restart_done", done, 0);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 300) begin cyc++; @(negedge clk); end
    chk("hold_second_done", done, 1);

    // Abort at busy cycle 40 with a stuck bit: fail is kept, done stays low
    stuck1 = 1'b1;
    @(negedge clk);
    chen = 3'b111; sel = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy_cycles(39);
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_csb", bus.sram_csb, 3'b111);
    chk("abort_fail_kept", fail, 3'b010);
    // abort and start together in IDLE: nothing starts
    start = 1'b1;
    @(negedge clk);
    chk("abort_start_busy", busy, 0);
    abort = 1'b0; start = 1'b0; stuck1 = 1'b0;
    run_test(3'b111, 2'b01, cyc, c1);
    chk("abort_rerun_cyc", cyc, BUSY_CYC);
    chk("abort_rerun_done", done, 1);
    chk("abort_rerun_fail", fail, 0);

    // Asynchronous reset in the middle of E2
    stuck1 = 1'b1;
    @(negedge clk);
    chen = 3'b111; sel = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy_cycles(59);
    chk("mid_e2_busy", busy, 1);
    chk("mid_e2_fail", fail, 3'b010);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_fail", fail, 0);
    chk("arst_fail_any", fail_any, 0);
    chk("arst_csb", bus.sram_csb, 3'b111);
    chk("arst_web", bus.sram_web, 1);
    chk("arst_addr", bus.sram_addr, 0);
    chk("arst_din", bus.sram_din, 0);
    @(negedge clk);
    rst = 1'b0; stuck1 = 1'b0;
    run_test(3'b111, 2'b10, cyc, c1);
    chk("arst_rerun_cyc", cyc, BUSY_CYC);
    chk("arst_rerun_done", done, 1);
    chk("arst_rerun_fail", fail, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
